// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - request/response handshake bundle for the branch controller
interface branch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_kind;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_imm;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;

    logic            resp_valid;
    logic            resp_ready;
    logic            resp_taken;
    logic [XLEN-1:0] resp_target;
    logic [XLEN-1:0] resp_link;
    logic            resp_illegal;
    logic            resp_misaligned;

    // Issuing side: drives requests, consumes results.
    modport master (
        output req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_taken, resp_target, resp_link, resp_illegal, resp_misaligned
    );

    // Controller side.
    modport slave (
        input  req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_taken, resp_target, resp_link, resp_illegal, resp_misaligned
    );
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/jump resolution sequencer with taken statistics
module branch_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    branch_ctrl_if.slave    bus,
    output logic            busy,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken
);
    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JAL    = 2'b01;
    localparam logic [1:0] KIND_JALR   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t state;

    // Instruction captured at acceptance; later input changes are ignored.
    logic [1:0]      kind_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;

    // Registered comparator output; keeps its value for undefined conditions.
    logic            cmp_q;

    logic            resp_valid_q;
    logic            resp_taken_q;
    logic [XLEN-1:0] resp_target_q;
    logic [XLEN-1:0] resp_link_q;
    logic            resp_illegal_q;
    logic            resp_misaligned_q;

    logic            cmp_next;
    logic            illegal_next;
    logic            taken_next;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target_next;
    logic [XLEN-1:0] link_next;

    // Comparator evaluation of the captured operands for the EVAL cycle.
    always_comb begin
        cmp_next = cmp_q;
        case (funct3_q)
            3'b000:  cmp_next = (rs1_q == rs2_q);
            3'b001:  cmp_next = (rs1_q != rs2_q);
            3'b100:  cmp_next = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  cmp_next = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  cmp_next = (rs1_q <  rs2_q);
            3'b111:  cmp_next = (rs1_q >= rs2_q);
            default: cmp_next = cmp_q;
        endcase
    end

    // Result fields derived from the captured instruction and comparator.
    always_comb begin
        illegal_next = (kind_q == 2'b11) ||
                       ((kind_q == KIND_BRANCH) && (funct3_q[2:1] == 2'b01));
        taken_next = 1'b0;
        case (kind_q)
            KIND_BRANCH: taken_next = cmp_next && !illegal_next;
            KIND_JAL:    taken_next = 1'b1;
            KIND_JALR:   taken_next = 1'b1;
            default:     taken_next = 1'b0;
        endcase
        jalr_sum    = rs1_q + imm_q;
        target_next = (kind_q == KIND_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
        link_next   = pc_q + XLEN'(4);
    end

    // Control FSM with registered result outputs and branch statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            kind_q            <= '0;
            funct3_q          <= '0;
            pc_q              <= '0;
            imm_q             <= '0;
            rs1_q             <= '0;
            rs2_q             <= '0;
            cmp_q             <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_taken_q      <= 1'b0;
            resp_target_q     <= '0;
            resp_link_q       <= '0;
            resp_illegal_q    <= 1'b0;
            resp_misaligned_q <= 1'b0;
            stat_branches     <= '0;
            stat_taken        <= '0;
        end else if (flush) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        kind_q   <= bus.req_kind;
                        funct3_q <= bus.req_funct3;
                        pc_q     <= bus.req_pc;
                        imm_q    <= bus.req_imm;
                        rs1_q    <= bus.req_rs1;
                        rs2_q    <= bus.req_rs2;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    cmp_q             <= cmp_next;
                    resp_taken_q      <= taken_next;
                    resp_target_q     <= target_next;
                    resp_link_q       <= link_next;
                    resp_illegal_q    <= illegal_next;
                    resp_misaligned_q <= taken_next && (target_next[1:0] != 2'b00);
                    resp_valid_q      <= 1'b1;
                    state             <= RESOLVE;
                end
                RESOLVE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                        if (kind_q == KIND_BRANCH && !resp_illegal_q) begin
                            stat_branches <= stat_branches + 32'd1;
                            if (resp_taken_q) begin
                                stat_taken <= stat_taken + 32'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready depends only on state, held low while reset is asserted.
    assign bus.req_ready       = (state == IDLE) && !rst;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_taken      = resp_taken_q;
    assign bus.resp_target     = resp_target_q;
    assign bus.resp_link       = resp_link_q;
    assign bus.resp_illegal    = resp_illegal_q;
    assign bus.resp_misaligned = resp_misaligned_q;
    assign busy                = (state != IDLE);

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl
module tb_branch_ctrl;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        busy;
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;

    int n_checks;
    int n_pass;

    branch_ctrl_if #(.XLEN(32)) bus ();

    branch_ctrl #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .bus           (bus),
        .busy          (busy),
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] kind, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] rs1, input logic [31:0] rs2);
        bus.req_valid  = 1'b1;
        bus.req_kind   = kind;
        bus.req_funct3 = f3;
        bus.req_pc     = pc;
        bus.req_imm    = imm;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
    endtask

    // Full transaction: accept, check 2-cycle latency and result, then handshake.
    task automatic run(input string tag, input logic [1:0] kind, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic e_taken, input logic [31:0] e_target,
                       input logic [31:0] e_link, input logic e_ill, input logic e_mis);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        present(kind, f3, pc, imm, rs1, rs2);
        tick;
        bus.req_valid = 1'b0;
        bus.req_rs1   = ~rs1;
        bus.req_rs2   = ~rs2;
        check({tag, ".eval_valid"}, 32'(bus.resp_valid), 32'd0);
        tick;
        check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, ".taken"},      32'(bus.resp_taken), 32'(e_taken));
        check({tag, ".target"},     bus.resp_target,     e_target);
        check({tag, ".link"},       bus.resp_link,       e_link);
        check({tag, ".illegal"},    32'(bus.resp_illegal), 32'(e_ill));
        check({tag, ".misaligned"}, 32'(bus.resp_misaligned), 32'(e_mis));
        bus.resp_ready = 1'b1;
        tick;
        bus.resp_ready = 1'b0;
        check({tag, ".idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.resp_ready = 1'b0;
        present(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.req_valid = 1'b0;
        tick;
        tick;
        check("rst.req_ready",  32'(bus.req_ready),  32'd0);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.busy",       32'(busy),           32'd0);
        check("rst.stat_br",    stat_branches,       32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.req_ready", 32'(bus.req_ready), 32'd1);

        run("beq",  2'b00, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120, 32'h104, 1'b0, 1'b0);
        check("beq.stat_br", stat_branches, 32'd1);
        check("beq.stat_tk", stat_taken,    32'd1);

        run("blt",  2'b00, 3'b100, 32'h200, 32'h10, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h210, 32'h204, 1'b0, 1'b0);
        run("bltu", 2'b00, 3'b110, 32'h200, 32'h10, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h210, 32'h204, 1'b0, 1'b0);
        check("blt.stat_br", stat_branches, 32'd3);
        check("blt.stat_tk", stat_taken,    32'd2);

        run("jalr_mis", 2'b10, 3'b000, 32'h300, 32'h2, 32'h1001, 32'h0, 1'b1, 32'h1002, 32'h304, 1'b0, 1'b1);
        run("jalr_ok",  2'b10, 3'b000, 32'h300, 32'h2, 32'h1003, 32'h0, 1'b1, 32'h1004, 32'h304, 1'b0, 1'b0);

        run("ill_f3",   2'b00, 3'b010, 32'h400, 32'h4, 32'h0, 32'h0, 1'b0, 32'h404, 32'h404, 1'b1, 1'b0);
        run("ill_kind", 2'b11, 3'b000, 32'h500, 32'h2, 32'h0, 32'h0, 1'b0, 32'h502, 32'h504, 1'b1, 1'b0);
        check("ill.stat_br", stat_branches, 32'd3);
        check("ill.stat_tk", stat_taken,    32'd2);

        run("jal_wrap", 2'b01, 3'b000, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0);
        run("bne_mis",  2'b00, 3'b001, 32'h600, 32'h6, 32'd1, 32'd2, 1'b1, 32'h606, 32'h604, 1'b0, 1'b1);
        run("bge",  2'b00, 3'b101, 32'h700, 32'h8, 32'd1, 32'hFFFFFFFF, 1'b1, 32'h708, 32'h704, 1'b0, 1'b0);
        run("bgeu", 2'b00, 3'b111, 32'h700, 32'h8, 32'd1, 32'hFFFFFFFF, 1'b0, 32'h708, 32'h704, 1'b0, 1'b0);
        run("beq_nt", 2'b00, 3'b000, 32'h700, 32'h8, 32'd1, 32'd2, 1'b0, 32'h708, 32'h704, 1'b0, 1'b0);
        check("mix.stat_br", stat_branches, 32'd7);
        check("mix.stat_tk", stat_taken,    32'd4);

        // Backpressure: result frozen, new requests ignored, single handshake.
        present(2'b00, 3'b000, 32'h800, 32'h40, 32'd7, 32'd7);
        tick;
        bus.req_valid = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            present(2'b01, 3'(i), 32'h1000 + 32'(i * 16), 32'h3, 32'(i), 32'h99);
            tick;
            check("bp.resp_valid", 32'(bus.resp_valid), 32'd1);
            check("bp.target",     bus.resp_target,     32'h840);
            check("bp.taken",      32'(bus.resp_taken), 32'd1);
            check("bp.req_ready",  32'(bus.req_ready),  32'd0);
        end
        bus.resp_ready = 1'b1;
        tick;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        check("bp.release_valid", 32'(bus.resp_valid), 32'd0);
        check("bp.release_busy",  32'(busy),           32'd0);
        tick;
        check("bp.no_accept", 32'(busy), 32'd0);
        check("bp.stat_br", stat_branches, 32'd8);
        check("bp.stat_tk", stat_taken,    32'd5);

        // Flush during EVAL.
        present(2'b00, 3'b000, 32'h900, 32'h4, 32'd3, 32'd3);
        tick;
        bus.req_valid = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("fl_eval.busy",  32'(busy),           32'd0);
        check("fl_eval.valid", 32'(bus.resp_valid), 32'd0);
        tick;
        check("fl_eval.valid2", 32'(bus.resp_valid), 32'd0);

        // Flush in RESOLVE coincident with resp_ready: no counter update.
        present(2'b00, 3'b000, 32'h900, 32'h4, 32'd3, 32'd3);
        tick;
        bus.req_valid = 1'b0;
        tick;
        check("fl_res.valid", 32'(bus.resp_valid), 32'd1);
        flush = 1'b1;
        bus.resp_ready = 1'b1;
        tick;
        flush = 1'b0;
        bus.resp_ready = 1'b0;
        check("fl_res.valid_off", 32'(bus.resp_valid), 32'd0);
        check("fl_res.stat_br", stat_branches, 32'd8);
        check("fl_res.stat_tk", stat_taken,    32'd5);

        // Reset while a result is pending.
        present(2'b10, 3'b000, 32'hA00, 32'h2, 32'h1001, 32'h0);
        tick;
        bus.req_valid = 1'b0;
        tick;
        check("rst_res.valid", 32'(bus.resp_valid), 32'd1);
        rst = 1'b1;
        tick;
        check("rst_res.req_ready", 32'(bus.req_ready),       32'd0);
        check("rst_res.valid0",    32'(bus.resp_valid),      32'd0);
        check("rst_res.taken",     32'(bus.resp_taken),      32'd0);
        check("rst_res.target",    bus.resp_target,          32'd0);
        check("rst_res.link",      bus.resp_link,            32'd0);
        check("rst_res.mis",       32'(bus.resp_misaligned), 32'd0);
        check("rst_res.busy",      32'(busy),                32'd0);
        check("rst_res.stat_br",   stat_branches,            32'd0);
        check("rst_res.stat_tk",   stat_taken,               32'd0);
        rst = 1'b0;
        #1;
        check("rst_res.req_ready1", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
